// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle control unit and its decoder.
package multicycle_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    // One-hot opcode bit positions of the control-flow and memory ops
    localparam int unsigned OP_LW  = 24;
    localparam int unsigned OP_SW  = 25;
    localparam int unsigned OP_BEQ = 26;
    localparam int unsigned OP_BNE = 27;
    localparam int unsigned OP_LUI = 28;
    localparam int unsigned OP_J   = 29;
    localparam int unsigned OP_JAL = 30;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Op-class masks, 64 bits wide so any N_OP up to 64 can slice them.
    // Ops 0..23 are ALU ops (0..8 register form, 9..23 immediate form).
    localparam logic [63:0] RF_WRITE_MASK = 64'h0000_0000_51FF_FFFF; // ALU, lw, lui, jal
    localparam logic [63:0] BRANCH_MASK   = 64'h0000_0000_6C00_0000; // beq, bne, j, jal
    localparam logic [63:0] MEM_MASK      = 64'h0000_0000_0300_0000; // lw, sw
    localparam logic [63:0] RT_DST_MASK   = 64'h0000_0000_11FF_FE00; // write rt, not rd
    localparam logic [63:0] IMM_MASK      = 64'h0000_0000_13FF_FE00; // ALU B from immediate
    localparam logic [63:0] SHIFT_MASK    = 64'h0000_0000_0000_01C0; // sll, srl, sra
    localparam logic [63:0] SEXT_MASK     = 64'h0000_0000_0F00_0200; // sign-extended imm

    // ALU function code contributed by a single opcode bit
    function automatic logic [3:0] aluc_of(input int unsigned idx);
        case (idx)
            1, OP_BEQ, OP_BNE: aluc_of = 4'b0100; // sub
            2:                 aluc_of = 4'b1000; // mul (long op when masked)
            3, 10:             aluc_of = 4'b0001; // and
            4, 11:             aluc_of = 4'b0101; // or
            5, 12:             aluc_of = 4'b0010; // xor
            6:                 aluc_of = 4'b0011; // sll
            7:                 aluc_of = 4'b0111; // srl
            8:                 aluc_of = 4'b1111; // sra
            OP_LUI:            aluc_of = 4'b0110; // lui
            default:           aluc_of = 4'b0000; // add
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode decoder: op_q/zero -> datapath mux selects, ALU code, op class.
module control_decode
    import multicycle_pkg::*;
#(
    parameter int unsigned N_OP = 31
) (
    input  logic [N_OP-1:0] op_q,
    input  logic            zero,
    output logic [8:0]      m,
    output logic [3:0]      aluc,
    output logic            is_mem,
    output logic            is_branch,
    output logic            writes_rf
);

    localparam logic [N_OP-1:0] RfMask     = RF_WRITE_MASK[N_OP-1:0];
    localparam logic [N_OP-1:0] BranchMask = BRANCH_MASK[N_OP-1:0];
    localparam logic [N_OP-1:0] MemMask    = MEM_MASK[N_OP-1:0];
    localparam logic [N_OP-1:0] RtDstMask  = RT_DST_MASK[N_OP-1:0];
    localparam logic [N_OP-1:0] ImmMask    = IMM_MASK[N_OP-1:0];
    localparam logic [N_OP-1:0] ShiftMask  = SHIFT_MASK[N_OP-1:0];
    localparam logic [N_OP-1:0] SextMask   = SEXT_MASK[N_OP-1:0];

    // Mux selects and op-class bits
    always_comb begin
        m         = '0;
        m[0]      = |(op_q & RtDstMask);
        m[1]      = (op_q[OP_BEQ] & zero) | (op_q[OP_BNE] & ~zero); // branch taken
        m[2]      = op_q[OP_J] | op_q[OP_JAL];
        m[3]      = |(op_q & ImmMask);
        m[4]      = op_q[OP_LW];                                  // load data to rf
        m[5]      = |(op_q & ShiftMask);
        m[6]      = |(op_q & SextMask);
        m[7]      = op_q[OP_JAL];                                 // link into r31
        m[8]      = op_q[OP_LUI];
        is_mem    = |(op_q & MemMask);
        is_branch = |(op_q & BranchMask);
        writes_rf = |(op_q & RfMask);
    end

    // ALU code: OR of the codes of the set opcode bits (op_q is one-hot when legal)
    always_comb begin
        aluc = 4'b0000;
        for (int unsigned i = 0; i < N_OP; i++) begin
            if (op_q[i]) aluc = aluc | aluc_of(i);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory and long-op handshakes.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned     N_OP         = 31,
    parameter logic [N_OP-1:0] LONG_OP_MASK = '0,
    parameter int unsigned     MEM_TIMEOUT  = 16,
    parameter int unsigned     CNT_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_OP-1:0] op,
    input  logic            zero,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            alu_done,
    output logic            pc_we,
    output logic            ir_we,
    output logic            im_r,
    output logic            dm_cs,
    output logic            dm_r,
    output logic            dm_w,
    output logic            rf_w,
    output logic            alu_start,
    output logic [8:0]      m,
    output logic [3:0]      aluc,
    output logic [2:0]      state,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    state_e          state_q, state_d;
    logic [N_OP-1:0] op_q, op_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            started_q, started_d;
    logic            trap_q, trap_d;
    logic [1:0]      cause_q, cause_d;

    logic is_mem, is_branch, writes_rf;
    logic long_op, op_legal;

    control_decode #(
        .N_OP(N_OP)
    ) u_decode (
        .op_q      (op_q),
        .zero      (zero),
        .m         (m),
        .aluc      (aluc),
        .is_mem    (is_mem),
        .is_branch (is_branch),
        .writes_rf (writes_rf)
    );

    assign long_op    = |(op_q & LONG_OP_MASK);
    assign op_legal   = (op != '0) && ((op & (op - N_OP'(1))) == '0);
    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            op_q       <= '0;
            wait_cnt_q <= '0;
            started_q  <= 1'b0;
            trap_q     <= 1'b0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            started_q  <= started_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
        end
    end

    // Next-state and enable decode; everything held low while rst is asserted
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = wait_cnt_q;
        started_d  = 1'b0;
        trap_d     = trap_q;
        cause_d    = cause_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        im_r       = 1'b0;
        dm_cs      = 1'b0;
        dm_r       = 1'b0;
        dm_w       = 1'b0;
        rf_w       = 1'b0;
        alu_start  = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    im_r = 1'b1;
                    if (imem_ready) begin
                        pc_we   = 1'b1;
                        ir_we   = 1'b1;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    op_d = op;
                    if (!op_legal) begin
                        state_d = StTrap;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    // started_q marks every EXEC cycle after the first
                    started_d = 1'b1;
                    alu_start = long_op && !started_q;
                    if (!long_op || alu_done) begin
                        pc_we = is_branch;
                        if (is_mem)         state_d = StMem;
                        else if (writes_rf) state_d = StWb;
                        else                state_d = StFetch;
                    end
                end
                StMem: begin
                    dm_cs = 1'b1;
                    dm_r  = op_q[OP_LW];
                    dm_w  = op_q[OP_SW];
                    if (dmem_ready) begin
                        wait_cnt_d = '0;
                        state_d    = op_q[OP_LW] ? StWb : StFetch;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        if (wait_cnt_d == CNT_W'(MEM_TIMEOUT)) begin
                            state_d = StTrap;
                            trap_d  = 1'b1;
                            cause_d = CAUSE_TIMEOUT;
                        end
                    end
                end
                StWb: begin
                    rf_w    = 1'b1;
                    state_d = StFetch;
                end
                StTrap: begin
                    state_d = StTrap;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

endmodule
